tx_frame_ctrl: RTL and testbench

PHY-side TX frame controller. It is the consumer of the MAC frame-start interface (new_frame, frame_vld, frame_len, frame_type). It validates each frame descriptor, builds and serializes the 24-bit 802.11a SIGNAL field, then pulls exactly frame_len payload bytes from the MAC through a request/valid handshake and forwards them to the scrambler/encoder chain. It reports done or err for every started frame.

---
 rtl/tx_frame_ctrl.sv | 177 +++++++++++++++++
 tb/tb_tx_frame_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_ctrl.sv
// tx_frame_ctrl: PHY-side TX frame controller.
// Accepts a frame descriptor from the MAC, rejects illegal descriptors and
// descriptor timeouts, serializes the 24-bit 802.11a SIGNAL field, and then
// pulls exactly frame_len payload bytes through a pld_req/pld_vld handshake.
// Every started frame ends with a done or err pulse.
// Ports:
//   clk, rst                    clock, async active-high reset
//   new_frame, frame_vld        descriptor announce / valid pulses
//   frame_len[15:0], frame_type[3:0]  descriptor fields
//   pld_req (out), pld_vld, pld_data[7:0]  payload pull handshake
//   sig_bit, sig_vld (out)      serialized SIGNAL field
//   byte_out[7:0], byte_vld (out)  forwarded payload
//   busy, done, err (out)       status
module tx_frame_ctrl #(
   parameter int unsigned MAX_LEN      = 4095,
   parameter int unsigned DESC_TIMEOUT = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        new_frame,
   input  logic        frame_vld,
   input  logic [15:0] frame_len,
   input  logic [3:0]  frame_type,
   output logic        pld_req,
   input  logic        pld_vld,
   input  logic [7:0]  pld_data,
   output logic        sig_bit,
   output logic        sig_vld,
   output logic [7:0]  byte_out,
   output logic        byte_vld,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_DESC,
      SIGNAL,
      PAYLOAD,
      DONE
   } state_t;

   localparam int unsigned TW = $clog2(DESC_TIMEOUT + 1);
   // The new_frame cycle itself counts toward the timeout, so the last
   // WAIT_DESC cycle is reached with the counter at DESC_TIMEOUT-2.
   localparam logic [TW-1:0] T_LAST = TW'(DESC_TIMEOUT - 2);

   state_t        state, state_nxt;
   logic [TW-1:0] tcnt;
   logic [4:0]    bcnt;
   logic [23:0]   sig_sr;
   logic [11:0]   cnt;
   logic [11:0]   len_q;

   logic desc_ok;
   logic load_desc;
   logic err_set;
   logic tclr;
   logic take;

   // SIGNAL word, bit 0 transmitted first: RATE R1..R4, reserved, LENGTH
   // LSB first, even parity over bits 0..16, six tail zeros.
   function automatic logic [23:0] sig_word(input logic [2:0] rate_idx,
                                            input logic [11:0] len);
      logic [3:0]  r;
      logic [23:0] w;
      unique case (rate_idx)
         3'd0: r = 4'b1101;
         3'd1: r = 4'b1111;
         3'd2: r = 4'b0101;
         3'd3: r = 4'b0111;
         3'd4: r = 4'b1001;
         3'd5: r = 4'b1011;
         3'd6: r = 4'b0001;
         3'd7: r = 4'b0011;
      endcase
      w       = '0;
      w[0]    = r[3];
      w[1]    = r[2];
      w[2]    = r[1];
      w[3]    = r[0];
      w[4]    = 1'b0;
      w[16:5] = len;
      w[17]   = ^w[16:0];
      return w;
   endfunction

   assign desc_ok = (frame_type <= 4'd7) && (frame_len != 16'd0) &&
                    ({16'd0, frame_len} <= MAX_LEN);

   always_comb begin
      state_nxt = state;
      load_desc = 1'b0;
      err_set   = 1'b0;
      tclr      = 1'b0;
      pld_req   = 1'b0;
      take      = 1'b0;
      busy      = (state != IDLE);
      sig_vld   = (state == SIGNAL);
      sig_bit   = (state == SIGNAL) & sig_sr[0];
      done      = (state == DONE);
      unique case (state)
         IDLE: begin
            if (new_frame) begin
               state_nxt = WAIT_DESC;
               tclr      = 1'b1;
            end
         end
         WAIT_DESC: begin
            if (frame_vld) begin
               if (desc_ok) begin
                  load_desc = 1'b1;
                  state_nxt = SIGNAL;
               end else begin
                  err_set   = 1'b1;
                  state_nxt = IDLE;
               end
            end else if (new_frame) begin
               tclr = 1'b1;
            end else if (tcnt == T_LAST) begin
               err_set   = 1'b1;
               state_nxt = IDLE;
            end
         end
         SIGNAL: begin
            if (bcnt == 5'd23) state_nxt = PAYLOAD;
         end
         PAYLOAD: begin
            pld_req = (cnt < len_q);
            take    = pld_req & pld_vld;
            if (take && (cnt + 12'd1 == len_q)) state_nxt = DONE;
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tcnt     <= '0;
         bcnt     <= '0;
         sig_sr   <= '0;
         cnt      <= '0;
         len_q    <= '0;
         byte_out <= '0;
         byte_vld <= 1'b0;
         err      <= 1'b0;
      end else begin
         err      <= err_set;
         byte_vld <= take;
         if (tclr)                    tcnt <= '0;
         else if (state == WAIT_DESC) tcnt <= tcnt + 1'b1;
         if (load_desc) begin
            len_q  <= frame_len[11:0];
            sig_sr <= sig_word(frame_type[2:0], frame_len[11:0]);
            bcnt   <= '0;
            cnt    <= '0;
         end else if (state == SIGNAL) begin
            sig_sr <= {1'b0, sig_sr[23:1]};
            bcnt   <= bcnt + 5'd1;
         end
         if (take) begin
            byte_out <= pld_data;
            cnt      <= cnt + 12'd1;
         end
      end
   end

endmodule

// File: tb/tb_tx_frame_ctrl.sv
// tb_tx_frame_ctrl: randomized self-checking bench for tx_frame_ctrl.
// A per-frame reference derives the SIGNAL bit sequence, error timing and
// payload byte stream from the frame rules and compares every cycle.
module tb_tx_frame_ctrl;
   localparam int DT = 8;
   localparam int ML = 4095;

   logic        clk = 1'b0;
   logic        rst;
   logic        new_frame, frame_vld;
   logic [15:0] frame_len;
   logic [3:0]  frame_type;
   logic        pld_req, pld_vld;
   logic [7:0]  pld_data;
   logic        sig_bit, sig_vld;
   logic [7:0]  byte_out;
   logic        byte_vld, busy, done, err;

   int total = 0;
   int bad   = 0;
   int gaps[$];

   tx_frame_ctrl #(.MAX_LEN(ML), .DESC_TIMEOUT(DT)) dut (
      .clk(clk), .rst(rst), .new_frame(new_frame), .frame_vld(frame_vld),
      .frame_len(frame_len), .frame_type(frame_type), .pld_req(pld_req),
      .pld_vld(pld_vld), .pld_data(pld_data), .sig_bit(sig_bit),
      .sig_vld(sig_vld), .byte_out(byte_out), .byte_vld(byte_vld),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   initial begin
      #3ms;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_err"}, err, 0);
      check({tag, "_sv"}, sig_vld, 0);
      check({tag, "_sb"}, sig_bit, 0);
      check({tag, "_req"}, pld_req, 0);
      check({tag, "_bv"}, byte_vld, 0);
   endtask

   // Builds the SIGNAL bits in transmit order; first bit ends up in bit 23.
   function automatic logic [23:0] ref_signal(input int len, input int typ);
      int rate_tab[8] = '{13, 15, 5, 7, 9, 11, 1, 3};
      bit q[$];
      int r, ones;
      logic [23:0] w;
      r = rate_tab[typ];
      for (int j = 3; j >= 0; j--) q.push_back(r[j]);
      q.push_back(1'b0);
      for (int j = 0; j < 12; j++) q.push_back((len >> j) & 1);
      ones = 0;
      foreach (q[i]) ones += q[i];
      q.push_back(ones % 2);
      for (int j = 0; j < 6; j++) q.push_back(1'b0);
      w = '0;
      foreach (q[i]) w = {w[22:0], q[i]};
      return w;
   endfunction

   function automatic int next_gap(input int mg);
      if (gaps.size() > 0) return gaps.pop_front();
      return $urandom_range(0, mg);
   endfunction

   // d: cycles from new_frame to frame_vld (0 = never, expect timeout)
   // restart: WAIT_DESC cycle at which new_frame is re-pulsed (0 = none)
   // abort_at: SIGNAL bit index at which rst is asserted (-1 = none)
   task automatic frame(input int len, input int typ, input int d, input int restart,
                        input int max_gap, input bit junk, input int abort_at);
      logic [23:0] expw, obsw;
      logic [7:0]  exp_bo, dat;
      bit legal;
      int k, last, acc, gap_left, exp_bv;
      legal = (typ <= 7) && (len >= 1) && (len <= ML);
      expw  = legal ? ref_signal(len, typ) : '0;
      @(negedge clk);
      new_frame = 1; frame_vld = 0; pld_vld = 0;
      last = 0;
      for (k = 1; k <= 40; k++) begin
         @(negedge clk);
         new_frame = 0;
         if (d == 0 && k - last == DT) begin
            check("to_err", err, 1);
            check("to_busy", busy, 0);
            @(negedge clk);
            check("to_err_clr", err, 0);
            check("to_idle", busy, 0);
            return;
         end
         check("wd_err", err, 0);
         check("wd_busy", busy, 1);
         check("wd_sig", sig_vld, 0);
         if (k == d) begin
            frame_vld  = 1;
            frame_len  = len[15:0];
            frame_type = typ[3:0];
            break;
         end
         if (k == restart) begin
            new_frame = 1;
            last = k;
         end
      end
      if (k > 40) return;
      @(negedge clk);
      frame_vld = 0;
      if (!legal) begin
         check("bad_err", err, 1);
         check("bad_busy", busy, 0);
         check("bad_sig", sig_vld, 0);
         @(negedge clk);
         check("bad_err_clr", err, 0);
         check("bad_idle", busy, 0);
         check("bad_sig2", sig_vld, 0);
         return;
      end
      obsw = '0;
      for (int i = 0; i < 24; i++) begin
         check("sig_vld", sig_vld, 1);
         check("sig_bit", sig_bit, expw[23-i]);
         check("sig_req", pld_req, 0);
         check("sig_bv", byte_vld, 0);
         check("sig_err", err, 0);
         obsw = {obsw[22:0], sig_bit};
         if (i == abort_at) begin
            rst = 1;
            #1;
            check("abort_out", byte_out, 0);
            check_quiet("abort");
            @(negedge clk);
            rst = 0; new_frame = 0; frame_vld = 0; pld_vld = 0;
            for (int j = 0; j < 3; j++) begin
               @(negedge clk);
               check_quiet("post_abort");
            end
            return;
         end
         if (junk) begin
            new_frame  = ($urandom_range(0, 3) == 0);
            frame_vld  = ($urandom_range(0, 3) == 0);
            frame_len  = 16'($urandom);
            frame_type = 4'($urandom);
            pld_vld    = 1'($urandom);
            pld_data   = 8'($urandom);
         end
         @(negedge clk);
      end
      new_frame = 0; frame_vld = 0;
      check("sig_end", sig_vld, 0);
      if (len == 10 && typ == 0)
         check("sig_tp1", obsw, 24'b1101_0010_1000_0000_0100_0000);
      acc = 0; exp_bv = 0; exp_bo = '0;
      gap_left = next_gap(max_gap);
      for (int c = 0; c < 20000; c++) begin
         check("req", pld_req, (acc < len));
         check("bv", byte_vld, exp_bv);
         if (exp_bv != 0) check("bo", byte_out, exp_bo);
         if (acc == len) begin
            check("done", done, 1);
            check("done_busy", busy, 1);
            break;
         end
         check("nodone", done, 0);
         check("pl_busy", busy, 1);
         if (junk) begin
            new_frame = ($urandom_range(0, 3) == 0);
            frame_vld = ($urandom_range(0, 3) == 0);
         end
         if (gap_left > 0) begin
            pld_vld  = 0;
            pld_data = 8'($urandom);
            gap_left--;
            exp_bv = 0;
         end else begin
            dat      = 8'($urandom);
            pld_vld  = 1;
            pld_data = dat;
            acc++;
            exp_bv = 1;
            exp_bo = dat;
            if (acc < len) gap_left = next_gap(max_gap);
         end
         @(negedge clk);
      end
      // pld_vld stays high here: no extra byte may be accepted
      new_frame = 0; frame_vld = 0; pld_vld = 1;
      @(negedge clk);
      check("fin_busy", busy, 0);
      check("fin_done", done, 0);
      check("fin_bv", byte_vld, 0);
      check("fin_req", pld_req, 0);
      check("fin_err", err, 0);
      pld_vld = 0;
   endtask

   initial begin
      int len, typ, d, rs;
      rst = 1; new_frame = 0; frame_vld = 0; frame_len = '0; frame_type = '0;
      pld_vld = 0; pld_data = '0;
      repeat (3) @(negedge clk);
      check("rst_out", byte_out, 0);
      check_quiet("rst");
      rst = 0;

      // frame_vld without new_frame is ignored
      @(negedge clk);
      frame_vld = 1; frame_len = 16'd5; frame_type = 4'd0;
      @(negedge clk);
      frame_vld = 0;
      check_quiet("orphan_vld");
      @(negedge clk);
      check_quiet("orphan_vld2");

      frame(10, 0, 1, 0, 0, 0, -1);
      frame(10, 9, 1, 0, 0, 0, -1);
      frame(0, 0, 1, 0, 0, 0, -1);
      frame(4096, 0, 2, 0, 0, 0, -1);
      frame(65535, 8, 3, 0, 0, 0, -1);
      frame(5, 0, 0, 0, 0, 0, -1);
      frame(4, 3, 7, 0, 1, 0, -1);
      frame(5, 0, 0, 3, 0, 0, -1);
      frame(9, 6, 5, 2, 1, 0, -1);
      frame(1, 7, 1, 0, 0, 0, -1);
      gaps = '{0, 5, 2};
      frame(3, 2, 1, 0, 0, 0, -1);
      frame(20, 5, 1, 0, 1, 1, 11);
      frame(6, 4, 2, 0, 2, 0, -1);
      frame(ML, 1, 1, 0, 0, 0, -1);

      for (int n = 0; n < 40; n++) begin
         len = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : 4096 + $urandom_range(0, 100))
                                           : $urandom_range(1, 40);
         typ = ($urandom_range(0, 7) == 0) ? $urandom_range(8, 15) : $urandom_range(0, 7);
         d   = $urandom_range(0, 7);
         rs  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
         if (d > 0 && rs >= d) rs = 0;
         frame(len, typ, d, rs, 3, 1, -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
